mc_mainfsm: RTL
===============

// Module: mc_mainfsm
// PURPOSE
//  Moore main FSM sequencing the multicycle ARM datapath: shared memory port, ALU reuse for PC+4, IR/PC write strobes.
//  Sits beside decode/condlogic in the multicycle controller; condlogic gates RegW/MemW/Branch with CondEx, not this block.
//  Optional multi-cycle MUL execution state with iteration counter.
// PARAMETERS
//  MUL_CYCLES  4  cycles spent in EXECM (legal 1..16); ignored unless MUL_EN defined
// PORTS
//  clk        in   1  clock, all state on rising edge
//  reset      in   1  asynchronous, active-low reset
//  Op         in   2  Instr[27:26]
//  Funct      in   6  Instr[25:20]
//  MulOp      in   4  Instr[7:4]
//  MemReady   in   1  shared memory completes access this cycle
//  IRWrite    out  1  load instruction register
//  NextPC     out  1  PC <= ALUResult (PC+4)
//  AdrSrc     out  1  0=PC, 1=ALUOut to memory address
//  ALUSrcA    out  1  0=RD1, 1=PC
//  ALUSrcB    out  2  00=RD2, 01=ExtImm, 10=const 4
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUOp      out  1  1=ALU decoder uses Funct, 0=ADD
//  RegW       out  1  raw register write
//  MemW       out  1  raw memory write
//  Branch     out  1  raw branch
//  MulSel     out  1  ALUOut sourced from multiplier
//  MulBusy    out  1  EXECM active
//  IllegalOp  out  1  1-cycle pulse: Op=11 seen in DECODE
//  State      out  4  current state code (debug)
// BEHAVIOUR
//  States/codes: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 EXECI7 ALUWB8 BRANCH9 EXECM10.
//  Reset (reset=0): State=FETCH, mul counter=0; IRWrite,NextPC,RegW,MemW,Branch,MulBusy,MulSel,IllegalOp=0; muxes at FETCH values.
//  Reset mid-operation abandons the instruction; first cycle after release is FETCH.
//  FETCH: AdrSrc0 ALUSrcA1 ALUSrcB10 ALUOp0 ResultSrc10; IRWrite=NextPC=MemReady; stay until MemReady=1 -> DECODE.
//  DECODE: ALUSrcA1 ALUSrcB10 ResultSrc10. Op=01->MEMADR; Op=10->BRANCH; Op=11->FETCH + IllegalOp;
//   Op=00: Funct[5]=1->EXECI; MUL pattern (Funct[5:1]=00000, MulOp=1001) ->EXECM if MUL_EN; else EXECR.
//  MEMADR: ALUSrcA0 ALUSrcB01 ALUOp0; Funct[0]=1->MEMRD else MEMWR.
//  MEMRD: AdrSrc1 ResultSrc00; MemReady=1->MEMWB else hold. MEMWB: ResultSrc01 RegW1 ->FETCH.
//  MEMWR: AdrSrc1 MemW1 held every cycle until MemReady=1 ->FETCH.
//  EXECR: ALUSrcA0 ALUSrcB00 ALUOp1. EXECI: ALUSrcA0 ALUSrcB01 ALUOp1.
//   From EXECR/EXECI: Funct[4:3]=10 (TST/TEQ/CMP/CMN) ->FETCH, else ->ALUWB.
//  ALUWB: ResultSrc00 RegW1 (MulSel1 if entered from EXECM) ->FETCH. BRANCH: ALUSrcA0 ALUSrcB01 ResultSrc10 Branch1 ->FETCH.
//  Latency (MemReady=1): LDR 5, STR 4, DP 4, CMP 3, B 3 cycles; each MemReady=0 cycle adds one.
//  Unlisted outputs are 0 in every state; all outputs are functions of State and MemReady only.
// CONFIGURATION
//  MUL_EN defined: EXECM entry loads counter=MUL_CYCLES-1; MulBusy1 MulSel1; counter decrements each cycle;
//   counter==0 -> ALUWB with MulSel1. MUL_CYCLES=1 gives exactly one EXECM cycle.
//  MUL_EN undefined: EXECM unreachable, MUL pattern decodes as EXECR (AND), MulSel=MulBusy=0, no counter flops.
// STRUCTURE
//  mc_pkg: state localparams (4-bit codes above), ALUSrcB/ResultSrc encodings, MUL pattern constant 4'b1001.
//  Sub-module mc_mul_counter (load/decrement/zero flag, width $clog2(MUL_CYCLES)+1), instantiated only under MUL_EN.
// TESTING
//  LDR (Op=01,Funct[0]=1), MemReady=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegW=1 only in MEMWB, ResultSrc=01.
//  STR with MemReady=0 for 2 MEMWR cycles -> MemW=1 for 3 cycles, then FETCH; no RegW.
//  FETCH with MemReady=0 for 3 cycles -> IRWrite/NextPC stay 0, then pulse 1 cycle; DECODE follows.
//  CMP (Op=00,Funct=010101) -> FETCH,DECODE,EXECR,FETCH; RegW never asserted; ADD imm (Funct=101000) -> EXECI,ALUWB.
//  MUL_EN, MUL_CYCLES=4, MulOp=1001, Funct=000000 -> MulBusy=1 exactly 4 cycles, ALUWB with MulSel=1; without MUL_EN -> EXECR.
//  Op=11 -> IllegalOp 1 cycle, back to FETCH; reset=0 asserted in EXECM -> State=0 and strobes 0 immediately.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM main controller FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_EXECM  = 4'd10
    } state_t;

    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [3:0] MUL_PATTERN   = 4'b1001;

    // fetch marks the state whose IRWrite/NextPC follow MemReady
    typedef struct packed {
        logic       fetch;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       mul_busy;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_MEMADR: c.alu_src_b = SRCB_IMM;
            S_MEMRD:  c.adr_src   = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = 1'b1;
            end
            S_EXECI: begin
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURESULT;
                c.branch     = 1'b1;
            end
            S_EXECM:  c.mul_busy = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_mainfsm_if.sv
// Instruction fields, memory handshake and control strobes between main FSM and datapath.
interface mc_mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] MulOp;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       MulSel;
    logic       MulBusy;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op, Funct, MulOp, MemReady,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               RegW, MemW, Branch, MulSel, MulBusy, IllegalOp, State
    );

    modport slave (
        output Op, Funct, MulOp, MemReady,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               RegW, MemW, Branch, MulSel, MulBusy, IllegalOp, State
    );
endinterface

// File: rtl/mc_mul_counter.sv
// Iteration counter for the EXECM state: load, decrement to zero, zero flag.
module mc_mul_counter #(
    parameter int MUL_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = $clog2(MUL_CYCLES) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(MUL_CYCLES - 1);
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/mc_mainfsm.sv
// Moore main FSM of the multicycle ARM controller; define MUL_EN to enable the
// multi-cycle EXECM multiply state (length MUL_CYCLES).
module mc_mainfsm
    import mc_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    mc_mainfsm_if.master bus
);
    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   mul_sel_q;
    logic   illegal_q;
    logic   mul_hit;
    logic   mul_done;

    if ((MUL_CYCLES < 1) || (MUL_CYCLES > 16)) begin : g_bad_mul_cycles
        $error("mc_mainfsm: MUL_CYCLES must be in 1..16");
    end

`ifdef MUL_EN
    assign mul_hit = (bus.Funct[5:1] == 5'b00000) && (bus.MulOp == MUL_PATTERN);

    mc_mul_counter #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul_counter (
        .clk  (clk),
        .reset(reset),
        .load ((state == S_DECODE) && (state_nxt == S_EXECM)),
        .dec  (state == S_EXECM),
        .zero (mul_done)
    );
`else
    assign mul_hit  = 1'b0;
    assign mul_done = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (bus.MemReady) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    2'b11:   state_nxt = S_FETCH;
                    default: begin
                        if (bus.Funct[5])  state_nxt = S_EXECI;
                        else if (mul_hit)  state_nxt = S_EXECM;
                        else               state_nxt = S_EXECR;
                    end
                endcase
            end
            S_MEMADR: state_nxt = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.MemReady) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (bus.MemReady) state_nxt = S_FETCH;
            // compare-class ops only set flags, so they skip the writeback
            S_EXECR, S_EXECI: state_nxt = (bus.Funct[4:3] == 2'b10) ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_EXECM:  if (mul_done) state_nxt = S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with State.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            ctrl      <= state_ctrl(S_FETCH);
            mul_sel_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctrl      <= state_ctrl(state_nxt);
            mul_sel_q <= (state_nxt == S_EXECM) ||
                         ((state_nxt == S_ALUWB) && (state == S_EXECM));
            illegal_q <= (state == S_DECODE) && (bus.Op == 2'b11);
        end
    end

    // reset gates the fetch strobes so nothing is loaded while held in reset
    assign bus.IRWrite   = ctrl.fetch & bus.MemReady & reset;
    assign bus.NextPC    = ctrl.fetch & bus.MemReady & reset;
    assign bus.AdrSrc    = ctrl.adr_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ResultSrc = ctrl.result_src;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.RegW      = ctrl.reg_w;
    assign bus.MemW      = ctrl.mem_w;
    assign bus.Branch    = ctrl.branch;
    assign bus.MulBusy   = ctrl.mul_busy;
    assign bus.MulSel    = mul_sel_q;
    assign bus.IllegalOp = illegal_q;
    assign bus.State     = state;
endmodule
